// File: rtl/cpu_pkg.sv
// Shared definitions for the adding CPU: default widths, opcode set and
// the control FSM state encoding.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDA = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_OUT = 3'd4,
    OP_JMP = 3'd5,
    OP_JZ  = 3'd6,
    OP_HLT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_EXEC,
    S_OUTP,
    S_HALT
  } state_e;

endpackage

// File: rtl/ac_alu.sv
// Combinational accumulator ALU: result and carry/borrow for LDA/ADD/SUB.
// Any other opcode passes the operand through and keeps the incoming carry.
module ac_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Zero-extended subtract: the extra MSB is the borrow (ac_i < opnd_i).
  always_comb begin
    sum     = {1'b0, ac_i} + {1'b0, opnd_i};
    diff    = {1'b0, ac_i} - {1'b0, opnd_i};
    res_o   = opnd_i;
    carry_o = carry_i;
    case (op_i)
      OP_ADD:  {carry_o, res_o} = sum;
      OP_SUB:  {carry_o, res_o} = diff;
      default: ;
    endcase
  end

endmodule

// File: rtl/ac_load_sequencer.sv
// Fetch/decode/execute sequencer for the adding CPU: drives program memory
// reads, the accumulator load strobe and the output port handshake.
module ac_load_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] ac_q,
  output logic              ld_ac,
  output logic [DATA_W-1:0] ac_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              carry,
  output logic              busy,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              carry_q, carry_d;

  logic              mem_req_q, ld_ac_q, out_valid_q, busy_q, halted_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  opcode_e           op;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign op      = opcode_e'(ir_q[DATA_W-1 -: 3]);
  assign ir_addr = ir_q[ADDR_W-1:0];

  ac_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (op),
    .ac_i    (ac_q),
    .opnd_i  (opnd_q),
    .carry_i (carry_q),
    .res_o   (alu_res),
    .carry_o (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_ADDR;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_NOP:                 state_d = S_FETCH;
          OP_LDA, OP_ADD, OP_SUB: state_d = S_OPER;
          OP_OUT:                 state_d = S_OUTP;
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (ac_q == '0) pc_d = ir_addr;
            state_d = S_FETCH;
          end
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_FETCH;
        endcase
      end
      S_OPER: begin
        if (mem_ack) begin
          opnd_d  = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        carry_d = alu_carry;
        state_d = S_FETCH;
      end
      S_OUTP: begin
        if (out_ready) state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = START_ADDR;
          carry_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d = '0;
    if (state_d == S_FETCH)     mem_addr_d = pc_d;
    else if (state_d == S_OPER) mem_addr_d = ir_d[ADDR_W-1:0];
  end

  // Control outputs are registered from the next state, so each one is a
  // pure function of the state register it accompanies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= START_ADDR;
      ir_q        <= '0;
      opnd_q      <= '0;
      carry_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ld_ac_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      opnd_q      <= opnd_d;
      carry_q     <= carry_d;
      mem_req_q   <= (state_d == S_FETCH) || (state_d == S_OPER);
      mem_addr_q  <= mem_addr_d;
      ld_ac_q     <= (state_d == S_EXEC);
      out_valid_q <= (state_d == S_OUTP);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q    <= (state_d == S_HALT);
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ld_ac     = ld_ac_q;
  assign ac_data   = ld_ac_q ? alu_res : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? ac_q : '0;
  assign carry     = carry_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule
